// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave
//    Wishbone B4 registered-feedback slave in front of a DEPTH-word, 32-bit RAM.
//    It handles classic single cycles and incrementing bursts (all bte wrap modes).
//    Accesses that fall outside the RAM window end with err instead of ack.
//
// Ports
//    clk          system clock
//    reset        asynchronous, active-high reset
//    addr         word address (30 bits)
//    bte          burst type extension: 0 linear, 1 wrap4, 2 wrap8, 3 wrap16
//    cti          cycle type: 0 classic, 1 const-addr, 2 incrementing, 7 end-of-burst
//    cyc          bus cycle active
//    stb          strobe
//    we           write enable
//    sel          byte lane enables, bit n covers data bits [8n+7:8n]
//    data_write   write data
//    ack          normal termination (registered)
//    err          error termination (registered)
//    data_read    read data, valid while ack is high
//    write_count  number of completed RAM writes, wraps at 16'hFFFF -> 0
module wishbone_ram_slave #(
   parameter logic [29:0] BASE_ADDR = 30'h1000_0000,
   parameter int          DEPTH     = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] addr,
   input  logic [1:0]  bte,
   input  logic [2:0]  cti,
   input  logic        cyc,
   input  logic [31:0] data_write,
   input  logic [3:0]  sel,
   input  logic        stb,
   input  logic        we,
   output logic        ack,
   output logic [31:0] data_read,
   output logic        err,
   output logic [15:0] write_count
);

   localparam int          IDX_W   = $clog2(DEPTH);
   localparam int          IDX_W1  = IDX_W + 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      CLASSIC,
      BURST
   } state_t;

   state_t             state_q, state_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [31:0]        data_read_q, data_read_d;
   logic [15:0]        write_count_q, write_count_d;
   logic [IDX_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [31:0]        mem [DEPTH];

   logic [29:0]        offset;
   logic               in_window;
   logic [IDX_W-1:0]   addr_idx;
   logic [IDX_W:0]     lin_sum;
   logic [IDX_W-1:0]   wrap_inc;
   logic [IDX_W-1:0]   wrap_mask;
   logic [IDX_W-1:0]   next_idx;
   logic               next_out;
   logic               beat_en;
   logic [IDX_W-1:0]   beat_idx;
   logic               ram_we;
   logic [31:0]        merged;

   // Window decode of the master's address, used only on the first beat.
   always_comb begin
      offset    = addr - BASE_ADDR;
      in_window = (addr >= BASE_ADDR) && (offset < DEPTH_W);
      addr_idx  = offset[IDX_W-1:0];
   end

   // Predicted index of the next burst beat. A linear burst carrying out of
   // the top index has walked past the window; wrap modes stay inside their
   // aligned block, which is always smaller than the RAM.
   always_comb begin
      lin_sum  = {1'b0, burst_cnt_q} + IDX_W1'(1);
      wrap_inc = burst_cnt_q + IDX_W'(1);
      case (bte)
         2'd1:    wrap_mask = IDX_W'(3);
         2'd2:    wrap_mask = IDX_W'(7);
         default: wrap_mask = IDX_W'(15);
      endcase
      if (bte == 2'd0) begin
         next_idx = lin_sum[IDX_W-1:0];
         next_out = lin_sum[IDX_W];
      end else begin
         next_idx = (burst_cnt_q & ~wrap_mask) | (wrap_inc & wrap_mask);
         next_out = 1'b0;
      end
   end

   // Next-state logic. A "beat" is one RAM access whose termination is
   // registered for the following cycle. CLASSIC ignores the bus so a master
   // still holding stb while it waits for ack cannot start a second access.
   always_comb begin
      state_d       = state_q;
      ack_d         = 1'b0;
      err_d         = 1'b0;
      data_read_d   = 32'd0;
      write_count_d = write_count_q;
      burst_cnt_d   = burst_cnt_q;
      beat_en       = 1'b0;
      beat_idx      = addr_idx;

      if (!cyc) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (stb) begin
                  if (in_window) begin
                     beat_en = 1'b1;
                     ack_d   = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  // A burst that starts outside the window has nothing to
                  // continue, so it is terminated like a single cycle.
                  if (cti == 3'd2 && in_window) begin
                     state_d     = BURST;
                     burst_cnt_d = addr_idx;
                  end else begin
                     state_d = CLASSIC;
                  end
               end
            end
            CLASSIC: begin
               state_d = IDLE;
            end
            BURST: begin
               if (stb) begin
                  if (next_out) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     beat_en     = 1'b1;
                     beat_idx    = next_idx;
                     ack_d       = 1'b1;
                     burst_cnt_d = next_idx;
                     if (cti != 3'd2) begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      ram_we = beat_en & we;
      if (beat_en) begin
         if (we) begin
            write_count_d = write_count_q + 16'd1;
         end else begin
            data_read_d = mem[beat_idx];
         end
      end

      for (int n = 0; n < 4; n++) begin
         merged[8*n +: 8] = sel[n] ? data_write[8*n +: 8] : mem[beat_idx][8*n +: 8];
      end
   end

   // RAM contents survive reset; writes are blocked while reset is high so an
   // interrupted access never lands.
   always_ff @(posedge clk) begin
      if (ram_we && !reset) begin
         mem[beat_idx] <= merged;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ack_q         <= 1'b0;
         err_q         <= 1'b0;
         data_read_q   <= 32'd0;
         write_count_q <= 16'd0;
         burst_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         err_q         <= err_d;
         data_read_q   <= data_read_d;
         write_count_q <= write_count_d;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

   assign ack         = ack_q;
   assign err         = err_q;
   assign data_read   = data_read_q;
   assign write_count = write_count_q;

endmodule
